// File: rtl/dma_xfer_ctrl_pkg.sv
// dma_xfer_ctrl shared definitions.
// Sequencer states, burst default and descriptor alignment.
package dma_pkg;

   localparam int unsigned BURST_BYTES_DEF = 64;
   localparam int unsigned DESC_ALIGN = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_REQ,
      ST_RD_WAIT,
      ST_WR_REQ,
      ST_WR_WAIT,
      ST_NEXT,
      ST_CMD_REQ,
      ST_CMD_WAIT
   } state_t;

   // Descriptors are 16-byte aligned; next_addr omits the low bits.
   function automatic logic [31:0] desc_addr(input logic [27:0] na);
      return {na, {DESC_ALIGN{1'b0}}};
   endfunction

endpackage

// File: rtl/dma_xfer_ctrl_if.sv
// dma_xfer_ctrl channel bus.
// Read, write and descriptor request/acknowledge handshakes.
interface dma_xfer_ctrl_if;

   logic        rd_req;
   logic [31:0] rd_addr;
   logic [15:0] rd_len;
   logic        rd_ack;
   logic        rd_done;

   logic        wr_req;
   logic [31:0] wr_addr;
   logic [15:0] wr_len;
   logic        wr_ack;
   logic        wr_done;

   logic        cmd_req;
   logic [31:0] cmd_addr;
   logic        cmd_ack;
   logic        cmd_valid;

   modport master (
      output rd_req, rd_addr, rd_len,
      input  rd_ack, rd_done,
      output wr_req, wr_addr, wr_len,
      input  wr_ack, wr_done,
      output cmd_req, cmd_addr,
      input  cmd_ack, cmd_valid
   );

   modport slave (
      input  rd_req, rd_addr, rd_len,
      output rd_ack, rd_done,
      input  wr_req, wr_addr, wr_len,
      output wr_ack, wr_done,
      input  cmd_req, cmd_addr,
      output cmd_ack, cmd_valid
   );

endinterface

// File: rtl/dma_xfer_ctrl_burst_calc.sv
// dma_xfer_ctrl burst splitter.
// Tracks remaining bytes and both addresses; yields burst length.
module dma_burst_calc #(
   parameter int unsigned BURST_BYTES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        adv,
   input  logic [31:0] rd_in,
   input  logic [31:0] wr_in,
   input  logic [31:0] size_in,
   output logic [31:0] rd_addr,
   output logic [31:0] wr_addr,
   output logic [15:0] len,
   output logic        last
);

   localparam logic [31:0] BB = 32'(BURST_BYTES);

   logic [31:0] rem;
   logic [31:0] len_w;

   // Burst is the smaller of what is left and the max burst.
   always_comb begin
      len_w = (rem < BB) ? rem : BB;
      len   = len_w[15:0];
      last  = (rem <= BB);
   end

   // Load on command start, step forward after each written burst.
   always_ff @(posedge clk) begin
      if (reset) begin
         rem     <= '0;
         rd_addr <= '0;
         wr_addr <= '0;
      end else if (load) begin
         rem     <= size_in;
         rd_addr <= rd_in;
         wr_addr <= wr_in;
      end else if (adv) begin
         rem     <= rem - len_w;
         rd_addr <= rd_addr + len_w;
         wr_addr <= wr_addr + len_w;
      end
   end

endmodule

// File: rtl/dma_xfer_ctrl.sv
// dma_xfer_ctrl transfer sequencer.
// Splits commands into read/write bursts and walks the descriptor chain.
module dma_xfer_ctrl
   import dma_pkg::*;
#(
   parameter int unsigned BURST_BYTES = BURST_BYTES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_ch_start,
   input  logic [31:0] rd_start_addr,
   input  logic [31:0] wr_start_addr,
   input  logic [31:0] buffer_size,
   input  logic        set_int,
   input  logic        cmd_last,
   input  logic [27:0] next_addr,
   output logic [15:0] buffer_count,
   output logic [15:0] int_count,
   output logic        irq,
   output logic        busy,
   dma_xfer_ctrl_if.master bus
);

   state_t state;
   state_t nxt;

   logic        load;
   logic        adv;
   logic        enter_next;
   logic        si_eff;
   logic        set_int_q;
   logic        cmd_last_q;
   logic [27:0] next_addr_q;
   logic [31:0] b_rd_addr;
   logic [31:0] b_wr_addr;
   logic [15:0] b_len;
   logic        b_last;

   dma_burst_calc #(
      .BURST_BYTES (BURST_BYTES)
   ) u_calc (
      .clk     (clk),
      .reset   (reset),
      .load    (load),
      .adv     (adv),
      .rd_in   (rd_start_addr),
      .wr_in   (wr_start_addr),
      .size_in (buffer_size),
      .rd_addr (b_rd_addr),
      .wr_addr (b_wr_addr),
      .len     (b_len),
      .last    (b_last)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= nxt;
   end

   // Next-state logic; a zero-size command skips straight to NEXT.
   always_comb begin
      nxt  = state;
      load = 1'b0;
      adv  = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (wr_ch_start) begin
               load = 1'b1;
               nxt  = (buffer_size == '0) ? ST_NEXT : ST_RD_REQ;
            end
         end
         ST_RD_REQ:  if (bus.rd_ack)  nxt = ST_RD_WAIT;
         ST_RD_WAIT: if (bus.rd_done) nxt = ST_WR_REQ;
         ST_WR_REQ:  if (bus.wr_ack)  nxt = ST_WR_WAIT;
         ST_WR_WAIT: begin
            if (bus.wr_done) begin
               adv = 1'b1;
               nxt = b_last ? ST_NEXT : ST_RD_REQ;
            end
         end
         ST_NEXT:    nxt = cmd_last_q ? ST_IDLE : ST_CMD_REQ;
         ST_CMD_REQ: if (bus.cmd_ack) nxt = ST_CMD_WAIT;
         ST_CMD_WAIT: begin
            if (bus.cmd_valid) begin
               load = 1'b1;
               nxt  = (buffer_size == '0) ? ST_NEXT : ST_RD_REQ;
            end
         end
         default: nxt = ST_IDLE;
      endcase
   end

   // Counters move on entry to NEXT so they show during NEXT itself.
   always_comb begin
      enter_next = (nxt == ST_NEXT);
      si_eff     = load ? set_int : set_int_q;
   end

   // Latch the command attributes with each new command.
   always_ff @(posedge clk) begin
      if (reset) begin
         set_int_q   <= 1'b0;
         cmd_last_q  <= 1'b0;
         next_addr_q <= '0;
      end else if (load) begin
         set_int_q   <= set_int;
         cmd_last_q  <= cmd_last;
         next_addr_q <= next_addr;
      end
   end

   // Completion counters, free-running with 16-bit wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         buffer_count <= '0;
         int_count    <= '0;
      end else if (enter_next) begin
         buffer_count <= buffer_count + 16'd1;
         if (si_eff) int_count <= int_count + 16'd1;
      end
   end

   // Request outputs; address/len held at zero when not requesting.
   always_comb begin
      bus.rd_req   = (state == ST_RD_REQ);
      bus.rd_addr  = bus.rd_req ? b_rd_addr : '0;
      bus.rd_len   = bus.rd_req ? b_len : '0;
      bus.wr_req   = (state == ST_WR_REQ);
      bus.wr_addr  = bus.wr_req ? b_wr_addr : '0;
      bus.wr_len   = bus.wr_req ? b_len : '0;
      bus.cmd_req  = (state == ST_CMD_REQ);
      bus.cmd_addr = bus.cmd_req ? desc_addr(next_addr_q) : '0;
      irq          = (state == ST_NEXT) && set_int_q;
      busy         = (state != ST_IDLE);
   end

endmodule
